seg7x16: RTL and testbench

SEG7X16 -- requirements
Module: seg7x16

---
 rtl/seg7_pkg.sv | 17 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7x16.sv | 71 +++++++
 tb/tb_seg7x16.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: hex glyph table,
// blank pattern and the default scan divider width.
package seg7_pkg;

    localparam int SCAN_W_DEF = 15;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low glyphs for 0..F, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7x16.sv
// Time-multiplexed driver for eight seven-segment digits, either hex-decoded
// from a 32-bit word or raw segment bytes from a 64-bit word.
module seg7x16
    import seg7_pkg::*;
#(
    parameter int SCAN_W = SCAN_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] i_data,
    input  logic        disp_mode,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    localparam logic [SCAN_W-1:0] DIV_ONE = {{(SCAN_W-1){1'b0}}, 1'b1};

    logic [SCAN_W-1:0] div_p0;
    logic [2:0]        idx_p0;
    logic              vld_p0;
    logic [63:0]       data_p0;
    logic              mode_p0;

    logic [3:0]        nib;
    logic [7:0]        raw_byte;
    logic [7:0]        hex_seg;
    logic [7:0]        seg_next;
    logic [7:0]        sel_next;

    assign nib      = data_p0[{idx_p0, 2'b00} +: 4];
    assign raw_byte = data_p0[{idx_p0, 3'b000} +: 8];

    seg7_hex_decode u_hex_decode (
        .nib (nib),
        .seg (hex_seg)
    );

    // vld_p0 holds the display blank for the first edge after reset, so
    // digit 0 lights one edge after its captured data is available.
    always_comb begin
        sel_next = SEG_BLANK;
        seg_next = SEG_BLANK;
        if (vld_p0) begin
            sel_next = ~(8'h01 << idx_p0);
            seg_next = mode_p0 ? raw_byte : hex_seg;
        end
    end

    // Stage p0: divider, digit index and input capture; outputs registered after.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_p0  <= '0;
            idx_p0  <= '0;
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            mode_p0 <= 1'b0;
            o_sel   <= SEG_BLANK;
            o_seg   <= SEG_BLANK;
        end else begin
            div_p0  <= div_p0 + DIV_ONE;
            if (&div_p0)
                idx_p0 <= idx_p0 + 3'd1;
            vld_p0  <= 1'b1;
            data_p0 <= i_data;
            mode_p0 <= disp_mode;
            o_sel   <= sel_next;
            o_seg   <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7x16.sv
// Scoreboard bench for seg7x16 with SCAN_W = 2 (four cycles per digit).
module tb_seg7x16;

    logic        clk;
    logic        rst;
    logic [63:0] i_data;
    logic        disp_mode;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;

    int checks;
    int failures;

    localparam logic [7:0] HEX_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Scoreboard of {o_sel, o_seg} expected after each edge.
    logic [15:0] sb [$];

    // Reference state: edges since reset release and inputs captured last edge.
    int          n;
    logic [63:0] prev_data;
    logic        prev_mode;

    seg7x16 #(.SCAN_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .disp_mode (disp_mode),
        .o_seg     (o_seg),
        .o_sel     (o_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Applies one cycle of stimulus, pushes the expected output for that edge,
    // then advances past the edge.
    task automatic drive(input logic rst_v, input logic [63:0] data_v, input logic mode_v);
        logic [7:0] sel;
        logic [7:0] seg;
        int d;
        sel = 8'hFF;
        seg = 8'hFF;
        if (rst_v) begin
            n = 0;
        end else begin
            n++;
            if (n > 1) begin
                d   = ((n - 1) / 4) % 8;
                sel = ~(8'h01 << d);
                seg = prev_mode ? prev_data[d*8 +: 8] : HEX_TAB[prev_data[d*4 +: 4]];
            end
        end
        sb.push_back({sel, seg});
        prev_data = rst_v ? 64'd0 : data_v;
        prev_mode = rst_v ? 1'b0 : mode_v;
        rst       = rst_v;
        i_data    = data_v;
        disp_mode = mode_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'd0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if ({o_sel, o_seg} !== exp || exp !== 16'hFFFF) begin
                failures++;
                $display("FAIL reset_hold cyc%0d sel/seg=%h/%h expected %h/%h", i, o_sel, o_seg, exp[15:8], exp[7:0]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 64'd0, 1'b0);
            exp = sb.pop_front();
            checks++;
            if ({o_sel, o_seg} !== exp) begin
                failures++;
                $display("FAIL reset_release edge%0d sel/seg=%h/%h expected %h/%h", n, o_sel, o_seg, exp[15:8], exp[7:0]);
            end
        end
        checks++;
        if (o_sel !== 8'hFD) begin
            failures++;
            $display("FAIL reset_release_digit1 sel=%h expected fd", o_sel);
        end
    endtask

    task automatic test_hex();
        logic [15:0] exp;
        drive(1'b1, 64'd0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 72; i++) begin
            drive(1'b0, 64'h0000_0000_1234_ABCD, 1'b0);
            exp = sb.pop_front();
            checks++;
            if ({o_sel, o_seg} !== exp) begin
                failures++;
                $display("FAIL hex_scan edge%0d sel/seg=%h/%h expected %h/%h", n, o_sel, o_seg, exp[15:8], exp[7:0]);
            end
            if (n == 30 || n == 34) begin
                checks++;
                if ({o_sel, o_seg} !== ((n == 30) ? 16'h7FF9 : 16'hFEA1)) begin
                    failures++;
                    $display("FAIL hex_wrap edge%0d sel/seg=%h/%h", n, o_sel, o_seg);
                end
            end
        end
    endtask

    task automatic test_graphics();
        logic [15:0] exp;
        drive(1'b1, 64'd0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 36; i++) begin
            drive(1'b0, 64'h0102_0408_1020_4080, 1'b1);
            exp = sb.pop_front();
            checks++;
            if ({o_sel, o_seg} !== exp) begin
                failures++;
                $display("FAIL gfx_scan edge%0d sel/seg=%h/%h expected %h/%h", n, o_sel, o_seg, exp[15:8], exp[7:0]);
            end
            if (n == 2 || n == 30) begin
                checks++;
                if ({o_sel, o_seg} !== ((n == 2) ? 16'hFE80 : 16'h7F01)) begin
                    failures++;
                    $display("FAIL gfx_raw edge%0d sel/seg=%h/%h", n, o_sel, o_seg);
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [15:0] exp;
        drive(1'b1, 64'd0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 22; i++) begin
            drive(1'b0, 64'hFFFF_FFFF_0000_0000, (n >= 14));
            exp = sb.pop_front();
            checks++;
            if ({o_sel, o_seg} !== exp) begin
                failures++;
                $display("FAIL mode_switch edge%0d sel/seg=%h/%h expected %h/%h", n, o_sel, o_seg, exp[15:8], exp[7:0]);
            end
            if (n == 15 || n == 16) begin
                checks++;
                if ({o_sel, o_seg} !== ((n == 15) ? 16'hF7C0 : 16'hF700)) begin
                    failures++;
                    $display("FAIL mode_switch_lat edge%0d sel/seg=%h/%h", n, o_sel, o_seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        logic        r;
        int          step;
        drive(1'b1, 64'd0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 34; i++) begin
            r    = (i == 22 || i == 23);
            step = n;
            drive(r, 64'h0000_0000_1234_ABCD, 1'b0);
            exp = sb.pop_front();
            checks++;
            if ({o_sel, o_seg} !== exp) begin
                failures++;
                $display("FAIL reset_mid i%0d sel/seg=%h/%h expected %h/%h", i, o_sel, o_seg, exp[15:8], exp[7:0]);
            end
            if (i == 21 || i == 22 || i == 25) begin
                checks++;
                if (o_sel !== ((i == 21) ? 8'hDF : (i == 22) ? 8'hFF : 8'hFE)) begin
                    failures++;
                    $display("FAIL reset_mid_sel i%0d prev_n%0d sel=%h", i, step, o_sel);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n         = 0;
        prev_data = 64'd0;
        prev_mode = 1'b0;
        rst       = 1'b1;
        i_data    = 64'd0;
        disp_mode = 1'b0;
        test_reset();
        test_hex();
        test_graphics();
        test_mode_switch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
